adc_pair_acq_sequencer: RTL

Sequences conversion and serial readout of the two AD7643 converters (channel 0 and channel 1) and streams each sample pair into the shared 16-bit waveform buffer that the USB transfer path later reads out. The block takes start, stop and pointer-clear commands from the host command decoder. It drives CS, CNVST and SCLK to both ADCs and issues buffer writes with an auto-incrementing, wrapping address.

---
 rtl/adc_pair_acq_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/adc_pair_acq_sequencer.sv
// Conversion/readout sequencer for a pair of AD7643 ADCs; streams each
// sample pair into the waveform buffer with a wrapping write pointer.
module adc_pair_acq_sequencer #(
  parameter int NSAMP    = 8192,
  parameter int SCLK_DIV = 2,
  parameter int CNV_LOW  = 3,
  parameter int ADDR_W   = 14,
  parameter int BUSY_TO  = 255
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              STOP,
  input  logic              PCLR,
  input  logic              ADBUSY0,
  input  logic              ADBUSY1,
  input  logic              ADSDOUT0,
  input  logic              ADSDOUT1,
  output logic              ADCS,
  output logic              ADCNVST,
  output logic              ADSCLK,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [15:0]       WDATA,
  output logic [ADDR_W-1:0] SCOUNT,
  output logic              RUNNING,
  output logic              DONE,
  output logic              TOUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNV, S_BUSYW, S_SHIFT, S_WR0, S_WR1, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] NSAMP_C = (ADDR_W+1)'(NSAMP);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [5:0]        half_q, half_d;
  logic [17:0]       sr0_q, sr0_d, sr1_q, sr1_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, scount_q, scount_d;
  logic [ADDR_W:0]   scount_inc;
  logic              pend_q, pend_d, running_q, running_d;
  logic              done_q, done_d, tout_q, tout_d;
  logic              adcs_q, adcs_d, adcnvst_q, adcnvst_d;
  logic              adsclk_q, adsclk_d, we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    half_d     = half_q;
    sr0_d      = sr0_q;
    sr1_d      = sr1_q;
    ptr_d      = ptr_q;
    scount_d   = scount_q;
    scount_inc = {1'b0, scount_q} + (ADDR_W+1)'(1);
    pend_d     = pend_q;
    running_d  = running_q;
    done_d     = done_q;
    tout_d     = tout_q;

    if (STOP && (state_q inside {S_CNV, S_BUSYW, S_SHIFT, S_WR0}))
      pend_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = '0;
        if (PCLR) begin
          ptr_d    = '0;
          scount_d = '0;
          done_d   = 1'b0;
          tout_d   = 1'b0;
          state_d  = S_IDLE;
        end
        // STOP only vetoes a start from IDLE; it has no meaning in DONE
        if (START && (state_q == S_DONE || !STOP)) begin
          state_d   = S_CNV;
          running_d = 1'b1;
          scount_d  = '0;
          done_d    = 1'b0;
          tout_d    = 1'b0;
        end
      end
      S_CNV: begin
        if (cnt_q == 16'(CNV_LOW - 1)) begin
          state_d = S_BUSYW;
          cnt_d   = '0;
        end
      end
      S_BUSYW: begin
        if (cnt_q >= 16'd2 && !ADBUSY0 && !ADBUSY1) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else if (cnt_q == 16'(BUSY_TO - 1)) begin
          state_d   = S_IDLE;
          tout_d    = 1'b1;
          running_d = 1'b0;
          pend_d    = 1'b0;
          cnt_d     = '0;
        end
      end
      S_SHIFT: begin
        // odd half-periods are SCLK high; sample on the first cycle of each
        if (half_q[0] && cnt_q == '0) begin
          sr0_d = (sr0_q << 1) | 18'(ADSDOUT0);
          sr1_d = (sr1_q << 1) | 18'(ADSDOUT1);
        end
        if (cnt_q == 16'(SCLK_DIV - 1)) begin
          cnt_d = '0;
          if (half_q == 6'd35) state_d = S_WR0;
          else                 half_d  = half_q + 6'd1;
        end
      end
      S_WR0: begin
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = S_WR1;
      end
      S_WR1: begin
        ptr_d    = ptr_q + ADDR_W'(1);
        scount_d = scount_inc[ADDR_W-1:0];
        cnt_d    = '0;
        if (scount_inc == NSAMP_C) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          state_d   = S_IDLE;
          running_d = 1'b0;
          pend_d    = 1'b0;
        end else begin
          state_d = S_CNV;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they align with it
    adcs_d    = !(state_d inside {S_CNV, S_BUSYW, S_SHIFT, S_WR0, S_WR1});
    adcnvst_d = (state_d != S_CNV);
    adsclk_d  = (state_d == S_SHIFT) && half_d[0];
    we_d      = (state_d == S_WR0) || (state_d == S_WR1);
    wdata_d   = wdata_q;
    if (state_d == S_WR0) wdata_d = sr0_d[17:2];
    if (state_d == S_WR1) wdata_d = sr1_d[17:2];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      sr0_q     <= '0;
      sr1_q     <= '0;
      ptr_q     <= '0;
      scount_q  <= '0;
      pend_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      adcs_q    <= 1'b1;
      adcnvst_q <= 1'b1;
      adsclk_q  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      sr0_q     <= sr0_d;
      sr1_q     <= sr1_d;
      ptr_q     <= ptr_d;
      scount_q  <= scount_d;
      pend_q    <= pend_d;
      running_q <= running_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
      adcs_q    <= adcs_d;
      adcnvst_q <= adcnvst_d;
      adsclk_q  <= adsclk_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
    end
  end

  assign ADCS    = adcs_q;
  assign ADCNVST = adcnvst_q;
  assign ADSCLK  = adsclk_q;
  assign WE      = we_q;
  assign WADDR   = ptr_q;
  assign WDATA   = wdata_q;
  assign SCOUNT  = scount_q;
  assign RUNNING = running_q;
  assign DONE    = done_q;
  assign TOUT    = tout_q;

endmodule
